// File: rtl/instr_fetch_unit_pkg.sv
// COMET II shared definitions: opcodes, fetch FSM encoding and
// instruction length decode used by the fetch unit.
package comet2_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LD    = 8'h10;
    localparam logic [7:0] OP_ST    = 8'h11;
    localparam logic [7:0] OP_LAD   = 8'h12;
    localparam logic [7:0] OP_LD_R  = 8'h14;
    localparam logic [7:0] OP_ADDA  = 8'h20;
    localparam logic [7:0] OP_AND   = 8'h30;
    localparam logic [7:0] OP_CPA   = 8'h40;
    localparam logic [7:0] OP_SLA   = 8'h50;
    localparam logic [7:0] OP_JMI   = 8'h61;
    localparam logic [7:0] OP_JUMP  = 8'h64;
    localparam logic [7:0] OP_PUSH  = 8'h70;
    localparam logic [7:0] OP_POP   = 8'h71;
    localparam logic [7:0] OP_CALL  = 8'h80;
    localparam logic [7:0] OP_RET   = 8'h81;
    localparam logic [7:0] OP_SVC   = 8'hF0;

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        VALID  = 2'd2
    } fetch_state_e;

    function automatic logic is_two_word(input logic [7:0] op);
        logic two;
        two = 1'b0;
        case (op) inside
            8'h10, 8'h11, 8'h12,
            [8'h20:8'h23],
            [8'h30:8'h32],
            8'h40, 8'h41,
            [8'h50:8'h53],
            [8'h61:8'h66],
            8'h70, 8'h80, 8'hF0: two = 1'b1;
            default:             two = 1'b0;
        endcase
        return two;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decoder instruction handshake bundle.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr_w1;
    logic [15:0]       instr_w2;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_len2;

    modport master (
        output instr_valid,
        output instr_w1,
        output instr_w2,
        output instr_pc,
        output instr_len2,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_w1,
        input  instr_w2,
        input  instr_pc,
        input  instr_len2,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// COMET II instruction fetch: owns the PC, reads 1/2-word instructions
// from program RAM and presents them to the decoder one at a time.
module instr_fetch_unit
    import comet2_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic              mem_gnt,
    output logic              re,
    output logic [ADDR_W-1:0] raddr,
    input  logic [15:0]       rdata,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    instr_fetch_unit_if.master dec
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [15:0]       w1_q, w1_d;
    logic [15:0]       w2_q, w2_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              len2_q, len2_d;
    logic              fetching;

    assign fetching = (state_q == FETCH1) || (state_q == FETCH2);

    // reset gating keeps the RAM port quiet while rst_n is low
    assign re    = rst_n & mem_gnt & fetching;
    assign raddr = (state_q == FETCH2) ? pc_q + ADDR_W'(1) : pc_q;

    assign dec.instr_valid = valid_q;
    assign dec.instr_w1    = w1_q;
    assign dec.instr_w2    = w2_q;
    assign dec.instr_pc    = ipc_q;
    assign dec.instr_len2  = len2_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        ipc_d   = ipc_q;
        len2_d  = len2_q;
        unique case (state_q)
            FETCH1: begin
                if (mem_gnt) begin
                    w1_d   = rdata;
                    ipc_d  = pc_q;
                    len2_d = is_two_word(rdata[15:8]);
                    if (is_two_word(rdata[15:8])) begin
                        state_d = FETCH2;
                    end else begin
                        w2_d    = 16'h0000;
                        valid_d = 1'b1;
                        state_d = VALID;
                    end
                end
            end
            FETCH2: begin
                if (mem_gnt) begin
                    w2_d    = rdata;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (dec.instr_ready) begin
                    pc_d    = pc_q + (len2_q ? ADDR_W'(2) : ADDR_W'(1));
                    valid_d = 1'b0;
                    state_d = FETCH1;
                end
            end
            default: begin
                state_d = FETCH1;
                valid_d = 1'b0;
            end
        endcase
        // a redirect wins over everything, including an accepting handshake
        if (pc_load) begin
            pc_d    = pc_load_val;
            valid_d = 1'b0;
            state_d = FETCH1;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH1;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            w1_q    <= 16'h0000;
            w2_q    <= 16'h0000;
            ipc_q   <= '0;
            len2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            ipc_q   <= ipc_d;
            len2_q  <= len2_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit against a behavioural program RAM.
module tb_instr_fetch_unit;

    logic        mclk;
    logic        rst_n;
    logic        mem_gnt;
    logic        re;
    logic [15:0] raddr;
    logic [15:0] rdata;
    logic        pc_load;
    logic [15:0] pc_load_val;

    logic [15:0] mem [0:65535];

    int n_chk;
    int n_err;

    instr_fetch_unit_if #(.ADDR_W(16)) dec ();

    instr_fetch_unit #(
        .ADDR_W  (16),
        .RESET_PC(16'h0000)
    ) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .mem_gnt    (mem_gnt),
        .re         (re),
        .raddr      (raddr),
        .rdata      (rdata),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .dec        (dec.master)
    );

    assign rdata = re ? mem[raddr] : 16'hXXXX;

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk_instr(input string tag, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] pc,
                             input logic len2);
        chk({tag, ".valid"}, 32'(dec.instr_valid), 32'd1);
        chk({tag, ".w1"},    32'(dec.instr_w1), 32'(w1));
        chk({tag, ".w2"},    32'(dec.instr_w2), 32'(w2));
        chk({tag, ".pc"},    32'(dec.instr_pc), 32'(pc));
        chk({tag, ".len2"},  32'(dec.instr_len2), 32'(len2));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1210;
        mem[16'h0001] = 16'hA5A5;
        mem[16'h000C] = 16'h7100;
        mem[16'h000F] = 16'h8000;
        mem[16'h0010] = 16'h0020;
        mem[16'h0020] = 16'h7000;
        mem[16'h0021] = 16'h1111;
        mem[16'h0022] = 16'h1234;
        mem[16'h0023] = 16'hBEEF;
        mem[16'hFFFF] = 16'h1100;

        rst_n           = 1'b0;
        mem_gnt         = 1'b1;
        pc_load         = 1'b0;
        pc_load_val     = 16'h0000;
        dec.instr_ready = 1'b0;

        #12;
        chk("rst.re",    32'(re), 32'd0);
        chk("rst.valid", 32'(dec.instr_valid), 32'd0);
        chk("rst.w1",    32'(dec.instr_w1), 32'd0);
        chk("rst.pc",    32'(dec.instr_pc), 32'd0);
        chk("rst.raddr", 32'(raddr), 32'h0000);
        @(negedge mclk);
        rst_n = 1'b1;

        // LAD at 0000: two-word, valid two cycles after release
        tick();
        chk("lad.f2.valid", 32'(dec.instr_valid), 32'd0);
        chk("lad.f2.raddr", 32'(raddr), 32'h0001);
        tick();
        chk_instr("lad", 16'h1210, 16'hA5A5, 16'h0000, 1'b1);
        chk("lad.re", 32'(re), 32'd0);
        dec.instr_ready = 1'b1;
        tick();
        dec.instr_ready = 1'b0;
        chk("lad.next_raddr", 32'(raddr), 32'h0002);
        chk("lad.next_valid", 32'(dec.instr_valid), 32'd0);

        // redirect while in FETCH1 discards the word being read
        pc_load     = 1'b1;
        pc_load_val = 16'h000C;
        tick();
        pc_load = 1'b0;
        chk("jmp.raddr", 32'(raddr), 32'h000C);
        chk("jmp.valid", 32'(dec.instr_valid), 32'd0);

        // POP: one-word, valid one cycle after FETCH1
        tick();
        chk_instr("pop", 16'h7100, 16'h0000, 16'h000C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall.re", 32'(re), 32'd0);
            chk("stall.raddr", 32'(raddr), 32'h000C);
            chk("stall.w1", 32'(dec.instr_w1), 32'h7100);
            chk("stall.valid", 32'(dec.instr_valid), 32'd1);
        end
        dec.instr_ready = 1'b1;
        tick();
        dec.instr_ready = 1'b0;
        chk("pop.next_raddr", 32'(raddr), 32'h000D);

        // two NOPs step the pc to the CALL at 000F
        tick();
        chk_instr("nop_d", 16'h0000, 16'h0000, 16'h000D, 1'b0);
        dec.instr_ready = 1'b1;
        tick();
        dec.instr_ready = 1'b0;
        tick();
        chk_instr("nop_e", 16'h0000, 16'h0000, 16'h000E, 1'b0);
        dec.instr_ready = 1'b1;
        tick();
        dec.instr_ready = 1'b0;
        chk("call.f1.raddr", 32'(raddr), 32'h000F);
        tick();
        chk("call.f2.raddr", 32'(raddr), 32'h0010);
        chk("call.f2.valid", 32'(dec.instr_valid), 32'd0);
        pc_load     = 1'b1;
        pc_load_val = 16'h0020;
        tick();
        pc_load = 1'b0;
        chk("call.drop.valid", 32'(dec.instr_valid), 32'd0);
        chk("call.drop.raddr", 32'(raddr), 32'h0020);
        tick();
        chk("push.f2.valid", 32'(dec.instr_valid), 32'd0);
        chk("push.f2.raddr", 32'(raddr), 32'h0021);
        tick();
        chk_instr("push", 16'h7000, 16'h1111, 16'h0020, 1'b1);

        // grant withheld for 3 cycles in each fetch state
        dec.instr_ready = 1'b1;
        tick();
        dec.instr_ready = 1'b0;
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gnt1.re", 32'(re), 32'd0);
            chk("gnt1.raddr", 32'(raddr), 32'h0022);
            chk("gnt1.valid", 32'(dec.instr_valid), 32'd0);
        end
        mem_gnt = 1'b1;
        tick();
        chk("gnt.f2.raddr", 32'(raddr), 32'h0023);
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gnt2.re", 32'(re), 32'd0);
            chk("gnt2.raddr", 32'(raddr), 32'h0023);
            chk("gnt2.valid", 32'(dec.instr_valid), 32'd0);
            chk("gnt2.w1", 32'(dec.instr_w1), 32'h1234);
        end
        mem_gnt = 1'b1;
        tick();
        chk_instr("lad2", 16'h1234, 16'hBEEF, 16'h0022, 1'b1);

        // redirect and handshake together: no increment
        dec.instr_ready = 1'b1;
        pc_load         = 1'b1;
        pc_load_val     = 16'hFFFF;
        tick();
        dec.instr_ready = 1'b0;
        pc_load         = 1'b0;
        chk("prio.raddr", 32'(raddr), 32'hFFFF);
        chk("prio.valid", 32'(dec.instr_valid), 32'd0);

        // second word wraps to 0000
        tick();
        chk("wrap.raddr", 32'(raddr), 32'h0000);
        chk("wrap.re", 32'(re), 32'd1);
        tick();
        chk_instr("wrap", 16'h1100, 16'h1210, 16'hFFFF, 1'b1);
        dec.instr_ready = 1'b1;
        tick();
        dec.instr_ready = 1'b0;
        chk("wrap.next_raddr", 32'(raddr), 32'h0001);

        // async reset between edges while in FETCH2
        pc_load     = 1'b1;
        pc_load_val = 16'h0000;
        tick();
        pc_load = 1'b0;
        tick();
        tick();
        chk_instr("pre_rst", 16'h1210, 16'hA5A5, 16'h0000, 1'b1);
        pc_load     = 1'b1;
        pc_load_val = 16'h000F;
        tick();
        pc_load = 1'b0;
        tick();
        chk("arst.pre.raddr", 32'(raddr), 32'h0010);
        chk("arst.pre.w1", 32'(dec.instr_w1), 32'h8000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(dec.instr_valid), 32'd0);
        chk("arst.w1", 32'(dec.instr_w1), 32'h0000);
        chk("arst.re", 32'(re), 32'd0);
        chk("arst.raddr", 32'(raddr), 32'h0000);
        @(negedge mclk);
        rst_n = 1'b1;
        tick();
        chk("arst.f2.raddr", 32'(raddr), 32'h0001);
        tick();
        chk_instr("arst.refetch", 16'h1210, 16'hA5A5, 16'h0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sits directly upstream of the program RAM, between the RAM read port and the COMET II decoder.
- Owns the program counter and drives the RAM read port (re/raddr), sampling rdata.
- Assembles 1- or 2-word COMET II instructions and hands each complete instruction (word1, word2, pc) to the decoder over a valid/ready handshake.
- Supports PC redirect for JUMP/CALL/RET, and a bus grant input so data-side accesses can steal the RAM port.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- ADDR_W, 16, PC and raddr width.

Ports:
- mclk  input  1  system clock; all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_gnt  input  1  RAM read port granted to fetch this cycle.
- re  output  1  RAM read enable.
- raddr  output  16  RAM read address.
- rdata  input  16  RAM read data; combinational from raddr when re=1.
- pc_load  input  1  redirect request.
- pc_load_val  input  16  redirect target.
- instr_valid  output  1  instruction outputs valid.
- instr_ready  input  1  decoder accepts instruction.
- instr_w1  output  16  first word (opcode/r/x).
- instr_w2  output  16  second word (adr); 16'h0000 for 1-word instructions.
- instr_pc  output  16  address of instr_w1.
- instr_len2  output  1  1 = 2-word instruction.

Behaviour:
- Clock and reset: one clock (mclk); rst_n is asynchronous, active-low.
- Reset (rst_n=0, async):
  - state=FETCH1, pc=RESET_PC.
  - instr_valid=0, instr_w1=0, instr_w2=0, instr_pc=0, instr_len2=0.
  - re=0 while in reset.
- States: FETCH1, FETCH2, VALID.
- FETCH1: re=mem_gnt, raddr=pc.
  - If mem_gnt=1 at posedge: instr_w1<=rdata, instr_pc<=pc, instr_len2<=is_two_word(rdata[15:8]).
  - Then go to FETCH2 if two-word, else VALID with instr_w2<=0.
  - If mem_gnt=0: hold state, no capture.
- FETCH2: re=mem_gnt, raddr=pc+1 (mod 2^16).
  - If mem_gnt=1: instr_w2<=rdata, go to VALID.
  - If mem_gnt=0: hold.
- VALID: instr_valid=1, re=0. Outputs stable until handshake.
  - On instr_valid&instr_ready at posedge: pc<=pc+1 (1-word) or pc+2 (2-word), wrapping mod 2^16; go to FETCH1.
- Latency: 1-word instruction is valid 1 cycle after FETCH1 entry; 2-word is valid 2 cycles after (with mem_gnt=1). No prefetch; max one instruction in flight.
- Redirect:
  - pc_load=1 at posedge, in any state: pc<=pc_load_val, state<=FETCH1, instr_valid<=0.
  - Any partially fetched instruction is discarded.
  - pc_load takes priority over a simultaneous handshake; the handshake still counts as accepted by the decoder, but the pc increment is suppressed.
- Wrap: instruction at FFFFh whose second word is at 0000h fetches from raddr 0000h.
- is_two_word(op): true for op in {10,11,12, 20-23, 30-32, 40,41, 50-53, 61-66, 70, 80, F0}.
  - All other opcodes (incl. 00 NOP, 14-17, 24-27, 34-36, 44,45, 71, 81, undefined) are 1 word.
- raddr=pc when re=0 (don't-care for RAM; keep deterministic).

Decomposition:
- Package comet2_pkg:
  - opcode localparams (OP_NOP, OP_LAD, OP_PUSH, OP_POP, OP_JUMP, OP_CALL, OP_RET, ...).
  - fetch state encoding.
  - function is_two_word.
- No sub-module needed; the length decode lives in the package function.

Test Plan:
- Reset, RAM preloaded 0000:1210, 0001:A5A5, mem_gnt=1, ready=1 -> first valid 2 cycles after reset release with w1=1210, w2=A5A5, pc=0000, len2=1; next fetch raddr=0002.
- Word 7100 at 000C, ready=1 -> valid 1 cycle after FETCH1 with w1=7100, w2=0000, len2=0; next pc=000D.
- Hold instr_ready=0 for 5 cycles in VALID -> outputs stable, re=0, pc unchanged; on ready=1, pc advances exactly once.
- pc_load=1, pc_load_val=0020 during FETCH2 of CALL at 000F -> partial instruction dropped, no valid pulse; next valid w1=7000, w2=1111, pc=0020.
- mem_gnt=0 for 3 cycles in FETCH1 and then in FETCH2 -> re=0, no captures, state held; resumes with correct words, total latency +6 cycles.
- Assert rst_n=0 mid-FETCH2 (async, between edges) -> instr_valid drops immediately, pc=0000; after release, refetches from 0000.
